// File: rtl/sram_port_arbiter.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : sram_port_arbiter
// Description : Two-port round-robin arbiter and sequencer in front of a
//               single byte_sram. Each port presents a read or write command
//               and holds it until its grant pulse. The SRAM is driven with
//               registered enables, index and write data. Read data is
//               returned to the port that issued the read.
//
// Ports
//   sram_clk, sram_ares_n         clock, asynchronous active-low reset
//   a_req/a_we/a_idx/a_wdata      port A command (held until a_gnt)
//   a_gnt                         one-cycle pulse: A command accepted
//   a_rvalid/a_rdata              one-cycle pulse / held read data for A
//   b_*                           same as A, for port B
//   wr_enable/rd_enable           SRAM strobes (never both high)
//   ram_index/sram_data_in        SRAM address / write data
//   sram_data_out                 SRAM read data (0 when enables are equal)
//   busy                          high whenever a command is in flight
//
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int IDX_W  = 7,
    parameter int DATA_W = 8
) (
    input  logic              sram_clk,
    input  logic              sram_ares_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              wr_enable,
    output logic              rd_enable,
    output logic [IDX_W-1:0]  ram_index,
    output logic [DATA_W-1:0] sram_data_in,
    input  logic [DATA_W-1:0] sram_data_out,
    output logic              busy
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WRITE   = 2'd1;
    localparam logic [1:0] c_ST_READ    = 2'd2;
    localparam logic [1:0] c_ST_CAPTURE = 2'd3;

    logic [1:0]        r_state;
    logic              r_last_b;      // 1 = port B received the most recent grant
    logic              r_owner_b;     // port that owns the in-flight read
    logic              r_a_gnt;
    logic              r_b_gnt;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_wr_enable;
    logic              r_rd_enable;
    logic [IDX_W-1:0]  r_ram_index;
    logic [DATA_W-1:0] r_sram_data_in;
    logic              r_busy;

    logic              w_any_req;
    logic              w_sel_b;
    logic              w_sel_we;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [DATA_W-1:0] w_sel_wdata;

    // On contention the port that did not win last time goes next; a lone
    // requester always wins.
    assign w_any_req   = a_req | b_req;
    assign w_sel_b     = b_req & (~a_req | ~r_last_b);
    assign w_sel_we    = w_sel_b ? b_we    : a_we;
    assign w_sel_idx   = w_sel_b ? b_idx   : a_idx;
    assign w_sel_wdata = w_sel_b ? b_wdata : a_wdata;

    always_ff @(posedge sram_clk or negedge sram_ares_n) begin
        if (!sram_ares_n) begin
            r_state        <= c_ST_IDLE;
            r_last_b       <= 1'b1;       // A gets first priority out of reset
            r_owner_b      <= 1'b0;
            r_a_gnt        <= 1'b0;
            r_b_gnt        <= 1'b0;
            r_a_rvalid     <= 1'b0;
            r_b_rvalid     <= 1'b0;
            r_a_rdata      <= '0;
            r_b_rdata      <= '0;
            r_wr_enable    <= 1'b0;
            r_rd_enable    <= 1'b0;
            r_ram_index    <= '0;
            r_sram_data_in <= '0;
            r_busy         <= 1'b0;
        end else begin
            // Grant and read-valid are single-cycle pulses.
            r_a_gnt    <= 1'b0;
            r_b_gnt    <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_b      <= w_sel_b;
                        r_last_b       <= w_sel_b;
                        r_ram_index    <= w_sel_idx;
                        r_sram_data_in <= w_sel_wdata;
                        r_wr_enable    <= w_sel_we;
                        r_rd_enable    <= ~w_sel_we;
                        r_a_gnt        <= ~w_sel_b;
                        r_b_gnt        <= w_sel_b;
                        r_busy         <= 1'b1;
                        r_state        <= w_sel_we ? c_ST_WRITE : c_ST_READ;
                    end
                end

                c_ST_WRITE: begin
                    // SRAM samples the write on this edge.
                    r_wr_enable <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end

                c_ST_READ: begin
                    // SRAM registers read data on this edge; rd_enable must
                    // stay high so the data is not forced to 0 before capture.
                    r_state <= c_ST_CAPTURE;
                end

                c_ST_CAPTURE: begin
                    if (r_owner_b) begin
                        r_b_rdata  <= sram_data_out;
                        r_b_rvalid <= 1'b1;
                    end else begin
                        r_a_rdata  <= sram_data_out;
                        r_a_rvalid <= 1'b1;
                    end
                    r_rd_enable <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end

                default: begin
                    r_wr_enable <= 1'b0;
                    r_rd_enable <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign a_gnt        = r_a_gnt;
    assign b_gnt        = r_b_gnt;
    assign a_rvalid     = r_a_rvalid;
    assign b_rvalid     = r_b_rvalid;
    assign a_rdata      = r_a_rdata;
    assign b_rdata      = r_b_rdata;
    assign wr_enable    = r_wr_enable;
    assign rd_enable    = r_rd_enable;
    assign ram_index    = r_ram_index;
    assign sram_data_in = r_sram_data_in;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Self-checking bench for sram_port_arbiter with a behavioural
//               byte_sram model and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [6:0] a_idx, b_idx;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       wr_enable, rd_enable, busy;
    logic [6:0] ram_index;
    logic [7:0] sram_data_in, sram_data_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_model [128];   // expected SRAM contents
    bit         last_b_model;      // expected round-robin history

    // byte_sram: write on posedge with wr_enable, registered read with
    // rd_enable, output forced to 0 while the enables are equal.
    logic [7:0] sram_mem [128];
    logic [7:0] sram_q;
    always @(posedge clk) begin
        if (wr_enable && !rd_enable) sram_mem[ram_index] = sram_data_in;
        if (rd_enable && !wr_enable) sram_q <= sram_mem[ram_index];
    end
    assign sram_data_out = (wr_enable == rd_enable) ? 8'h00 : sram_q;

    sram_port_arbiter #(.IDX_W(7), .DATA_W(8)) dut (
        .sram_clk     (clk),
        .sram_ares_n  (rst_n),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_idx        (a_idx),
        .a_wdata      (a_wdata),
        .a_gnt        (a_gnt),
        .a_rvalid     (a_rvalid),
        .a_rdata      (a_rdata),
        .b_req        (b_req),
        .b_we         (b_we),
        .b_idx        (b_idx),
        .b_wdata      (b_wdata),
        .b_gnt        (b_gnt),
        .b_rvalid     (b_rvalid),
        .b_rdata      (b_rdata),
        .wr_enable    (wr_enable),
        .rd_enable    (rd_enable),
        .ram_index    (ram_index),
        .sram_data_in (sram_data_in),
        .sram_data_out(sram_data_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_req = 0; b_req = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        last_b_model = 1'b1;
    endtask

    task automatic test_reset();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_idx = 0; b_idx = 0; a_wdata = 0; b_wdata = 0;
        rst_n = 0;
        #3;
        total++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0) begin
            bad++; $display("FAIL reset_pulses: got %b want 0000", {a_gnt, b_gnt, a_rvalid, b_rvalid});
        end
        total++;
        if ({a_rdata, b_rdata} !== 16'h0) begin
            bad++; $display("FAIL reset_rdata: got a=%h b=%h want 00", a_rdata, b_rdata);
        end
        total++;
        if ({wr_enable, rd_enable, busy, ram_index, sram_data_in} !== 18'h0) begin
            bad++; $display("FAIL reset_sram: got wr=%b rd=%b busy=%b idx=%h din=%h want 0",
                            wr_enable, rd_enable, busy, ram_index, sram_data_in);
        end
        tick(); tick();
        rst_n = 1;
        tick();
        last_b_model = 1'b1;
    endtask

    task automatic test_single_port();
        a_req = 1; a_we = 1; a_idx = 7'h05; a_wdata = 8'h3C;
        tick();
        total++;
        if (a_gnt !== 1 || wr_enable !== 1 || rd_enable !== 0 || ram_index !== 7'h05 || sram_data_in !== 8'h3C) begin
            bad++; $display("FAIL single_wr_grant: got gnt=%b wr=%b rd=%b idx=%h din=%h want 1 1 0 05 3c",
                            a_gnt, wr_enable, rd_enable, ram_index, sram_data_in);
        end
        a_req = 0;
        mem_model[5] = 8'h3C;
        tick();
        total++;
        if (a_gnt !== 0 || wr_enable !== 0 || busy !== 0) begin
            bad++; $display("FAIL single_wr_done: got gnt=%b wr=%b busy=%b want 0 0 0", a_gnt, wr_enable, busy);
        end
        a_req = 1; a_we = 0; a_idx = 7'h05;
        tick();
        total++;
        if (a_gnt !== 1 || rd_enable !== 1 || wr_enable !== 0) begin
            bad++; $display("FAIL single_rd_grant: got gnt=%b rd=%b wr=%b want 1 1 0", a_gnt, rd_enable, wr_enable);
        end
        a_req = 0;
        tick();
        total++;
        if (a_rvalid !== 0 || rd_enable !== 1) begin
            bad++; $display("FAIL single_rd_mid: got rvalid=%b rd=%b want 0 1", a_rvalid, rd_enable);
        end
        tick();
        total++;
        if (a_rvalid !== 1 || a_rdata !== 8'h3C || rd_enable !== 0) begin
            bad++; $display("FAIL single_rd_data: got rvalid=%b rdata=%h rd=%b want 1 3c 0", a_rvalid, a_rdata, rd_enable);
        end
        tick();
        total++;
        if (a_rvalid !== 0 || a_rdata !== 8'h3C) begin
            bad++; $display("FAIL single_rd_hold: got rvalid=%b rdata=%h want 0 3c", a_rvalid, a_rdata);
        end
        total++;
        if (b_gnt !== 0 || b_rvalid !== 0 || b_rdata !== 8'h00) begin
            bad++; $display("FAIL single_b_quiet: got gnt=%b rvalid=%b rdata=%h want 0 0 00", b_gnt, b_rvalid, b_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int ag, bg, av, bv;
        logic [7:0] ad, bd;
        do_reset();
        a_req = 1; a_we = 1; a_idx = 7'h10; a_wdata = 8'hAA;
        b_req = 1; b_we = 1; b_idx = 7'h11; b_wdata = 8'h55;
        ag = -1; bg = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (a_gnt) begin ag = k; a_req = 0; end
            if (b_gnt) begin bg = k; b_req = 0; end
        end
        total++;
        if (ag != 0 || bg != 2) begin
            bad++; $display("FAIL simul_wr_order: got a=%0d b=%0d want 0 2", ag, bg);
        end
        mem_model[7'h10] = 8'hAA;
        mem_model[7'h11] = 8'h55;
        a_req = 1; a_we = 0; b_req = 1; b_we = 0;
        ag = -1; bg = -1; av = -1; bv = -1; ad = 0; bd = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (a_gnt) begin ag = k; a_req = 0; end
            if (b_gnt) begin bg = k; b_req = 0; end
            if (a_rvalid) begin av = k; ad = a_rdata; end
            if (b_rvalid) begin bv = k; bd = b_rdata; end
        end
        total++;
        if (ag != 0 || av != 2 || bg != 3 || bv != 5) begin
            bad++; $display("FAIL simul_rd_timing: got ag=%0d av=%0d bg=%0d bv=%0d want 0 2 3 5", ag, av, bg, bv);
        end
        total++;
        if (ad !== 8'hAA || bd !== 8'h55) begin
            bad++; $display("FAIL simul_rd_data: got a=%h b=%h want aa 55", ad, bd);
        end
    endtask

    task automatic test_back_to_back();
        int qa[$], qb[$];
        int ai, bi, ng, first, nrv;
        int e;
        for (int i = 0; i < 8; i++) begin
            a_req = 1; a_we = 1; a_idx = 7'(i); a_wdata = 8'(i);
            tick();
            total++;
            if (a_gnt !== 1) begin
                bad++; $display("FAIL b2b_preload_gnt: idx=%0d got %b want 1", i, a_gnt);
            end
            a_req = 0;
            mem_model[i] = 8'(i);
            tick();
        end
        do_reset();
        ai = 0; bi = 0; ng = 0; first = -1; nrv = 0;
        a_req = 1; a_we = 0; a_idx = 7'd0;
        b_req = 1; b_we = 0; b_idx = 7'd1;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if (wr_enable && rd_enable) begin
                bad++; $display("FAIL b2b_enable_overlap: cycle=%0d got wr=1 rd=1 want not both", k);
            end
            if (a_gnt || b_gnt) begin
                if (first < 0) first = k;
                total++;
                if (a_gnt === b_gnt || b_gnt !== ng[0] || (k - first) != 3 * ng) begin
                    bad++; $display("FAIL b2b_grant: grant#%0d got a=%b b=%b at +%0d want b=%0d at +%0d",
                                    ng, a_gnt, b_gnt, k - first, ng[0], 3 * ng);
                end
                ng++;
                if (a_gnt) begin
                    qa.push_back(int'(a_idx)); ai++;
                    if (ai < 4) a_idx = 7'(2 * ai); else a_req = 0;
                end
                if (b_gnt) begin
                    qb.push_back(int'(b_idx)); bi++;
                    if (bi < 4) b_idx = 7'(2 * bi + 1); else b_req = 0;
                end
            end
            if (a_rvalid) begin
                nrv++;
                e = (qa.size() > 0) ? qa.pop_front() : -1;
                total++;
                if (e < 0 || a_rdata !== 8'(e)) begin
                    bad++; $display("FAIL b2b_a_rdata: got %h want %0d", a_rdata, e);
                end
            end
            if (b_rvalid) begin
                nrv++;
                e = (qb.size() > 0) ? qb.pop_front() : -1;
                total++;
                if (e < 0 || b_rdata !== 8'(e)) begin
                    bad++; $display("FAIL b2b_b_rdata: got %h want %0d", b_rdata, e);
                end
            end
        end
        total++;
        if (ng != 8 || nrv != 8) begin
            bad++; $display("FAIL b2b_counts: got grants=%0d rvalids=%0d want 8 8", ng, nrv);
        end
        last_b_model = 1'b1;
    endtask

    task automatic test_sweep();
        bit seen [128];
        int nseen;
        for (int i = 0; i < 128; i++) seen[i] = 0;
        for (int i = 0; i < 128; i++) begin
            b_req = 1; b_we = 1; b_idx = 7'(i); b_wdata = 8'(~i);
            tick();
            total++;
            if (b_gnt !== 1 || ram_index !== 7'(i) || sram_data_in !== 8'(~i)) begin
                bad++; $display("FAIL sweep_wr: idx=%0d got gnt=%b ram_index=%h din=%h", i, b_gnt, ram_index, sram_data_in);
            end
            if (b_gnt === 1) seen[ram_index] = 1;
            b_req = 0;
            mem_model[i] = 8'(~i);
            tick();
            b_req = 1; b_we = 0;
            tick();
            b_req = 0;
            tick(); tick();
            total++;
            if (b_rvalid !== 1 || b_rdata !== 8'(~i)) begin
                bad++; $display("FAIL sweep_rd: idx=%0d got rvalid=%b rdata=%h want 1 %h", i, b_rvalid, b_rdata, 8'(~i));
            end
        end
        nseen = 0;
        for (int i = 0; i < 128; i++) nseen += int'(seen[i]);
        total++;
        if (nseen != 128) begin
            bad++; $display("FAIL sweep_coverage: got %0d indices want 128", nseen);
        end
        last_b_model = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        int rv;
        do_reset();
        a_req = 1; a_we = 0; a_idx = 7'h05;
        tick();
        total++;
        if (a_gnt !== 1) begin
            bad++; $display("FAIL midrst_gnt: got %b want 1", a_gnt);
        end
        a_req = 0;
        rst_n = 0;
        #1;
        total++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, wr_enable, rd_enable, busy, ram_index, sram_data_in, a_rdata, b_rdata} !== '0) begin
            bad++; $display("FAIL midrst_outputs: got gnt=%b rd=%b busy=%b idx=%h want all 0", a_gnt, rd_enable, busy, ram_index);
        end
        tick(); tick();
        rst_n = 1;
        last_b_model = 1'b1;
        rv = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (a_rvalid) rv++;
        end
        total++;
        if (rv != 0) begin
            bad++; $display("FAIL midrst_no_rvalid: got %0d pulses want 0", rv);
        end
        a_req = 1; a_we = 1; a_idx = 7'h20; a_wdata = 8'h11;
        b_req = 1; b_we = 1; b_idx = 7'h21; b_wdata = 8'h22;
        tick();
        total++;
        if (a_gnt !== 1 || b_gnt !== 0) begin
            bad++; $display("FAIL midrst_priority: got a=%b b=%b want 1 0", a_gnt, b_gnt);
        end
        a_req = 0;
        tick(); tick();
        b_req = 0;
        mem_model[7'h20] = 8'h11;
        mem_model[7'h21] = 8'h22;
        tick();
        last_b_model = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if ({wr_enable, rd_enable, busy} !== 3'b000 || sram_data_out !== 8'h00) begin
                bad++; $display("FAIL idle_quiet: cycle=%0d got wr=%b rd=%b busy=%b dout=%h want 0",
                                k, wr_enable, rd_enable, busy, sram_data_out);
            end
        end
    endtask

    // Transaction-level model: the arbiter is free from cycle free_at on; a
    // command granted at cycle c occupies 2 (write) or 3 (read) cycles and a
    // read returns memory contents at c+2.
    task automatic test_random(int ncyc);
        int free_at, rd_due, a_gap, b_gap;
        bit rd_pend, rd_port_b, a_has, b_has, eg_a, eg_b, sel_b, sel_we, erv_a, erv_b;
        logic [6:0] sel_idx;
        logic [7:0] rd_data;
        do_reset();
        free_at = 0; rd_pend = 0; rd_due = 0; rd_port_b = 0; rd_data = 0;
        a_has = 0; b_has = 0; a_gap = 0; b_gap = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (!a_has) begin
                if (a_gap > 0) a_gap--;
                else if ($urandom_range(2) != 0) begin
                    a_has = 1; a_we = 1'($urandom_range(1));
                    a_idx = 7'($urandom_range(127)); a_wdata = 8'($urandom_range(255));
                end
            end
            if (!b_has) begin
                if (b_gap > 0) b_gap--;
                else if ($urandom_range(2) != 0) begin
                    b_has = 1; b_we = 1'($urandom_range(1));
                    b_idx = 7'($urandom_range(127)); b_wdata = 8'($urandom_range(255));
                end
            end
            a_req = a_has; b_req = b_has;
            eg_a = 0; eg_b = 0;
            if (c >= free_at && (a_has || b_has)) begin
                sel_b   = (a_has && b_has) ? !last_b_model : b_has;
                sel_we  = sel_b ? b_we  : a_we;
                sel_idx = sel_b ? b_idx : a_idx;
                last_b_model = sel_b;
                if (sel_b) eg_b = 1; else eg_a = 1;
                if (sel_we) begin
                    mem_model[sel_idx] = sel_b ? b_wdata : a_wdata;
                    free_at = c + 2;
                end else begin
                    rd_pend = 1; rd_due = c + 2; rd_port_b = sel_b;
                    rd_data = mem_model[sel_idx];
                    free_at = c + 3;
                end
            end
            tick();
            erv_a = rd_pend && rd_due == c && !rd_port_b;
            erv_b = rd_pend && rd_due == c && rd_port_b;
            total++;
            if (a_gnt !== eg_a || b_gnt !== eg_b) begin
                bad++; $display("FAIL rnd_gnt: cycle=%0d got a=%b b=%b want a=%b b=%b", c, a_gnt, b_gnt, eg_a, eg_b);
            end
            total++;
            if (a_rvalid !== erv_a || b_rvalid !== erv_b) begin
                bad++; $display("FAIL rnd_rvalid: cycle=%0d got a=%b b=%b want a=%b b=%b", c, a_rvalid, b_rvalid, erv_a, erv_b);
            end
            if (erv_a || erv_b) begin
                total++;
                if ((erv_a ? a_rdata : b_rdata) !== rd_data) begin
                    bad++; $display("FAIL rnd_rdata: cycle=%0d port_b=%b got %h want %h",
                                    c, rd_port_b, erv_a ? a_rdata : b_rdata, rd_data);
                end
                rd_pend = 0;
            end
            total++;
            if (busy !== (c + 1 < free_at) || (wr_enable && rd_enable)) begin
                bad++; $display("FAIL rnd_busy_enables: cycle=%0d got busy=%b wr=%b rd=%b want busy=%b",
                                c, busy, wr_enable, rd_enable, (c + 1 < free_at));
            end
            if (eg_a) begin a_has = 0; a_gap = $urandom_range(3); end
            if (eg_b) begin b_has = 0; b_gap = $urandom_range(3); end
        end
        a_req = 0; b_req = 0;
        tick(); tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            sram_mem[i]  = 8'h00;
            mem_model[i] = 8'h00;
        end
        last_b_model = 1'b1;
        test_reset();
        test_single_port();
        test_simultaneous();
        test_back_to_back();
        test_sweep();
        test_reset_mid_read();
        test_idle();
        test_random(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of a single byte_sram instance.
- Accepts independent read/write commands from ports A and B.
- Drives the SRAM's wr_enable/rd_enable/ram_index/sram_data_in with registered, race-free timing, then returns read data to the owning port.
- Guarantees the SRAM never sees both enables high, and keeps rd_enable high through data capture.

Parameters:
- IDX_W, 7, SRAM index width (128 entries).
- DATA_W, 8, SRAM data width.

Ports:
- sram_clk  input  1  single clock; all state updates on posedge.
- sram_ares_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A command request; held with a_we/a_idx/a_wdata until a_gnt.
- a_we  input  1  1 = write, 0 = read.
- a_idx  input  IDX_W  target index.
- a_wdata  input  DATA_W  write data.
- a_gnt  output  1  one-cycle pulse: command accepted.
- a_rvalid  output  1  one-cycle pulse: a_rdata valid.
- a_rdata  output  DATA_W  read data; holds last value between pulses.
- b_req, b_we, b_idx, b_wdata, b_gnt, b_rvalid, b_rdata: identical to A, for port B.
- wr_enable  output  1  to SRAM.
- rd_enable  output  1  to SRAM.
- ram_index  output  IDX_W  to SRAM.
- sram_data_in  output  DATA_W  to SRAM.
- sram_data_out  input  DATA_W  from SRAM; forced 0 by SRAM when enables are equal.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, sram_ares_n=0):
  - state=IDLE, last_grant=B (so A has first priority).
  - All outputs 0: gnt, rvalid, rdata, wr_enable, rd_enable, ram_index, sram_data_in, busy.
- Reset asserted mid-operation: an in-flight read is discarded, with no rvalid after release; a write may or may not have landed in the SRAM.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, WRITE, READ, CAPTURE.
- IDLE:
  - No req: stay.
  - Exactly one req: select that port.
  - Both req: select the port != last_grant.
  - On select, at the same posedge:
    - latch owner/we/idx/wdata;
    - drive ram_index and sram_data_in;
    - set wr_enable=we, rd_enable=!we;
    - pulse gnt of the owner;
    - update last_grant=owner;
    - go to WRITE if we, else READ.
- WRITE:
  - The SRAM samples on this posedge.
  - Next posedge: wr_enable=0, go to IDLE.
  - Write occupancy is 2 cycles.
- READ:
  - The SRAM registers read data on this posedge; rd_enable stays 1.
  - Next posedge: go to CAPTURE.
- CAPTURE:
  - At posedge: owner rdata<=sram_data_out, owner rvalid=1 for one cycle, rd_enable=0, go to IDLE.
  - Read latency: gnt edge to rvalid edge = 2 cycles; occupancy 3 cycles.
- Arbitration is evaluated only in IDLE. Requests arriving in other states wait; there is no queue and no back-to-back issue from non-IDLE states.
- A requester keeping req high after gnt issues a new command. With both ports requesting continuously, grants strictly alternate A,B,A,B.
- Invariant: wr_enable & rd_enable is never 1. Both are 0 in IDLE.
- ram_index and sram_data_in hold their last values in IDLE; they change only on a grant edge.
- The non-owner's rvalid and rdata are untouched.
- No index range check: all 2^IDX_W indices are legal, with natural wrap.

Test Plan:
- Reset then A writes idx 0x05=0x3C, then A reads idx 0x05 -> a_gnt pulse each command; a_rvalid 2 cycles after the read grant with a_rdata=0x3C; b_* stay 0.
- A and B both assert req on the same cycle after reset (A wr 0x10=0xAA, B wr 0x11=0x55) -> A granted first, B granted 2 cycles later; reads then return 0xAA (to A) and 0x55 (to B).
- Both ports hold req continuously for 8 reads of idx 0..7 (preloaded with i) -> grants alternate A,B,A,B; each read occupies 3 cycles; every rdata=idx; never wr_enable&rd_enable.
- Sweep B write-then-read over all 128 indices with data=~idx -> all reads match; ram_index covers 0x00..0x7F.
- Deassert sram_ares_n during READ of a pending A read -> all outputs 0 immediately; no a_rvalid after release; next request is A-priority (last_grant=B).
- Idle with no req for 10 cycles -> wr_enable=rd_enable=0, busy=0, so sram_data_out is 0 (SRAM stall).
